noc_output_arbiter: RTL and testbench
=====================================

# noc_output_arbiter

Round-robin output-port arbiter for one router output (N, E, W, S or L). Takes the per-input port requests produced by the LBDR routing units, grants the output to one input for a whole packet (HEADER through TAIL), and gates flit transfer on a downstream credit counter. One instance per output port, sitting between the input FIFOs/LBDR stage and the output crossbar mux.

## Interface
- CREDITS, 4, downstream buffer depth in flits; initial and maximum credit count
- NPORTS, 5, number of input ports; index 0=N, 1=E, 2=W, 3=S, 4=L
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NPORTS  per-input request for this output (LBDR port bit of each input)
- empty  in  NPORTS  per-input FIFO empty flag
- flit_id  in  3*NPORTS  flit type of each input FIFO head; input i on bits [3i+2:3i]; HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100
- credit_in  in  1  one pulse returns one credit from downstream
- grant  out  NPORTS  one-hot registered owner of the output; 0 when idle
- sel  out  3  binary index of owner, crossbar mux select
- read_en  out  NPORTS  one-hot pop of owner's FIFO; flit transferred this cycle
- valid_out  out  1  OR of read_en; output flit valid
- credit_cnt  out  $clog2(CREDITS+1)  current credits

## Operation
- States: IDLE, LOCKED.
- IDLE: candidate i = req[i] & ~empty[i] & flit_id[i]==HEADER. If any candidate, pick first candidate searching from ptr upward with wrap modulo NPORTS; next cycle grant=onehot(i), sel=i, state=LOCKED, ptr=(i+1) mod NPORTS. No candidate: stay IDLE, ptr unchanged.
- LOCKED: read_en[owner] = ~empty[owner] & (credit_cnt!=0); all other read_en bits 0. Combinational from registered state and inputs.
- Packet end: read_en[owner] & flit_id[owner]==TAIL -> next cycle state=IDLE, grant=0, sel holds last value.
- req changes while LOCKED are ignored; lock releases only on TAIL transfer.
- Owner empty or credits 0: stall, no read_en, state held.
- Credits: read_en only -> -1; credit_in only -> +1; both -> unchanged. credit_in at CREDITS without a read saturates at CREDITS. Never decrements below 0 (guaranteed by read_en gating).
- Single-flit packet (HEADER with no TAIL) not supported; a packet always ends with TAIL.

## Timing
- Reset values: grant=0, sel=0, read_en=0, valid_out=0, credit_cnt=CREDITS, state=IDLE, ptr=0.
- rst mid-packet: return to reset values next edge; partially sent packet abandoned (upstream resets together).
- Arbitration latency: candidate HEADER in cycle t -> grant in t+1 -> HEADER read_en in t+1 if credits>0.
- Throughput while LOCKED: one flit per cycle given data and credits.
- TAIL transferred in cycle t -> IDLE in t+1 -> next grant earliest t+2 (one dead cycle between packets).
- credit_in in cycle t visible in credit_cnt at t+1; a flit can use it in t+1.

## Structure
- Shared package noc_pkg: port index constants (N/E/W/S/L), flit_id encodings HEADER/PAYLOAD/TAIL, arbiter state enum.
- Sub-module rr_picker: combinational, inputs cand[NPORTS] and ptr, outputs one-hot pick and index; reusable by other output ports and the VC allocator.

## Test plan
- Reset: hold rst 2 cycles, CREDITS=4 -> grant=0, read_en=0, credit_cnt=4, sel=0.
- Single packet: input E requests, HEADER,PAYLOAD,TAIL back-to-back -> grant=5'b00010 next cycle, read_en[1] for 3 cycles, credit_cnt 4->1, IDLE after TAIL.
- Round-robin fairness: N, W, L all requesting 2-flit packets continuously from ptr=0 -> grant order N, W, L, N, ... with one idle cycle between packets.
- Lock hold: while E locked, input S raises HEADER request and E deasserts req -> grant stays E until E's TAIL, then S granted.
- Credit stall: CREDITS=2, 4-flit packet, no credit_in -> 2 flits sent, read_en 0 with credit_cnt=0; one credit_in pulse -> exactly one flit next cycle.
- Simultaneous events and reset: read_en with credit_in same cycle -> credit_cnt unchanged; rst asserted mid-packet -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: port indices, flit type encodings and arbiter state shared across the router
package noc_pkg;
   localparam int PORT_N = 0;
   localparam int PORT_E = 1;
   localparam int PORT_W = 2;
   localparam int PORT_S = 3;
   localparam int PORT_L = 4;
   localparam logic [2:0] HEADER = 3'b001;
   localparam logic [2:0] PAYLOAD = 3'b010;
   localparam logic [2:0] TAIL = 3'b100;
   typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set candidate at or above ptr, wrapping modulo NPORTS
module rr_picker #(
   parameter int NPORTS = 5,
   parameter int IW = 3
) (
   input  logic [NPORTS-1:0] cand,
   input  logic [IW-1:0]     ptr,
   output logic [NPORTS-1:0] pick,
   output logic [IW-1:0]     idx,
   output logic              any
);
   localparam logic [IW:0] NP = (IW+1)'(NPORTS);
   logic [IW:0] p;
   assign any = |cand;
   always_comb begin
      p = '0;
      idx = '0;
      for (int k = NPORTS-1; k >= 0; k--) begin
         p = {1'b0, ptr} + (IW+1)'(k);
         p = p >= NP ? p - NP : p;
         if (cand[p[IW-1:0]]) idx = p[IW-1:0];
      end
      pick = any ? NPORTS'(1) << idx : '0;
   end
endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin per-packet output ownership with downstream credit gating
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter int CREDITS = 4,
   parameter int NPORTS = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NPORTS-1:0]            req,
   input  logic [NPORTS-1:0]            empty,
   input  logic [3*NPORTS-1:0]          flit_id,
   input  logic                         credit_in,
   output logic [NPORTS-1:0]            grant,
   output logic [2:0]                   sel,
   output logic [NPORTS-1:0]            read_en,
   output logic                         valid_out,
   output logic [$clog2(CREDITS+1)-1:0] credit_cnt
);
   localparam int CW = $clog2(CREDITS+1);
   localparam logic [CW-1:0] CMAX = CW'(CREDITS);
   localparam logic [2:0] LAST = 3'(NPORTS-1);
   arb_state_t state;
   logic [2:0] ptr, pick_idx;
   logic [NPORTS-1:0] cand, pick;
   logic any, xfer;
   logic [2:0] fid [NPORTS];
   for (genvar i = 0; i < NPORTS; i++) begin : g_in
      assign fid[i] = flit_id[3*i +: 3];
      assign cand[i] = req[i] & ~empty[i] & (fid[i] == HEADER);
   end
   rr_picker #(.NPORTS(NPORTS), .IW(3)) u_pick (
      .cand(cand),
      .ptr(ptr),
      .pick(pick),
      .idx(pick_idx),
      .any(any)
   );
   assign xfer = state == LOCKED && !empty[sel] && credit_cnt != '0;
   assign read_en = xfer ? grant : '0;
   assign valid_out = |read_en;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         sel <= '0;
         ptr <= '0;
         credit_cnt <= CMAX;
      end else begin
         if (xfer && !credit_in) credit_cnt <= credit_cnt - CW'(1);
         else if (!xfer && credit_in && credit_cnt != CMAX) credit_cnt <= credit_cnt + CW'(1);
         if (state == IDLE && any) begin
            state <= LOCKED;
            grant <= pick;
            sel <= pick_idx;
            ptr <= pick_idx == LAST ? '0 : pick_idx + 3'd1;
         end else if (xfer && fid[sel] == TAIL) begin
            state <= IDLE;
            grant <= '0;
         end
      end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: random traffic against a packet-level arbitration and credit model
module tb_noc_output_arbiter;
   localparam int C = 4;
   localparam int N = 5;
   logic clk = 0;
   logic rst;
   logic [N-1:0] req, empty, grant, read_en;
   logic [3*N-1:0] flit_id;
   logic credit_in, valid_out;
   logic [2:0] sel, credit_cnt;
   int checks = 0, errors = 0;
   int owner = -1, ptr = 0, credits = C, last_sel = 0, pos = 0, len = 2, cprob = 2;
   always #5 clk = ~clk;
   noc_output_arbiter #(.CREDITS(C), .NPORTS(N)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .empty(empty),
      .flit_id(flit_id),
      .credit_in(credit_in),
      .grant(grant),
      .sel(sel),
      .read_en(read_en),
      .valid_out(valid_out),
      .credit_cnt(credit_cnt)
   );
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // Owner's head follows its packet; other inputs show arbitrary traffic.
   task automatic drive(bit r);
      rst = r;
      credit_in = ($urandom_range(cprob-1) == 0);
      for (int i = 0; i < N; i++) begin
         req[i] = 1'($urandom_range(1));
         if (i == owner) begin
            empty[i] = ($urandom_range(3) == 0);
            flit_id[3*i +: 3] = pos == 0 ? 3'b001 : pos == len-1 ? 3'b100 : 3'b010;
         end else begin
            empty[i] = ($urandom_range(2) == 0);
            flit_id[3*i +: 3] = 3'b001 << $urandom_range(2);
         end
      end
   endtask
   task automatic cycle(bit r);
      bit rd;
      drive(r);
      @(negedge clk);
      rd = owner >= 0 && !empty[owner] && credits > 0;
      check("grant", 32'(grant), owner < 0 ? 0 : 1 << owner);
      check("sel", 32'(sel), last_sel);
      check("read_en", 32'(read_en), rd ? 1 << owner : 0);
      check("valid_out", 32'(valid_out), 32'(rd));
      check("credit_cnt", 32'(credit_cnt), credits);
      @(posedge clk);
      if (r) begin
         owner = -1; ptr = 0; credits = C; last_sel = 0;
      end else begin
         if (rd && !credit_in) credits--;
         else if (!rd && credit_in && credits < C) credits++;
         if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
               int p = (ptr + k) % N;
               if (req[p] && !empty[p] && flit_id[3*p +: 3] == 3'b001) begin
                  owner = p; last_sel = p; ptr = (p + 1) % N; pos = 0;
                  len = $urandom_range(5, 2);
                  break;
               end
            end
         end else if (rd) begin
            if (pos == len-1) owner = -1;
            else pos++;
         end
      end
      #1;
   endtask
   initial begin
      rst = 1; req = '0; empty = '1; flit_id = '0; credit_in = 0;
      repeat (2) @(posedge clk);
      #1;
      cycle(0);
      cprob = 2;
      repeat (1500) cycle($urandom_range(299) == 0);
      cprob = 8;
      repeat (1500) cycle($urandom_range(299) == 0);
      cprob = 1;
      repeat (300) cycle(0);
      cycle(1);
      cycle(0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
